da_frame_tx: RTL and testbench

Serial frame generator for the DA link of the analog-output (AO) channel path. It accepts 16-bit AO codes through a valid/ready handshake and buffers one pending code. Each code is serialized MSB-first on the DA SPI data line, inside a byte-aligned write frame: 0x55 header, channel byte, sequence byte, 0x01 write command, then the code. The block sits directly upstream of the AO channel receiver, which decodes the frame and loops the code back over the AD readback path.

---
 rtl/da_frame_tx.sv | 178 +++++++++++++++++
 tb/tb_da_frame_tx.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/da_frame_tx.sv
// -----------------------------------------------------------------------------
// da_frame_tx
// -----------------------------------------------------------------------------
// Serial write-frame generator for the DA link of the analog-output channel.
// Accepts 16-bit AO codes over a valid/ready handshake into a one-entry
// holding buffer. Each code goes out MSB-first on o_da_spi_sdo inside a
// byte-aligned frame:
//   0x55, channel, sequence, 0x01, code[15:8], code[7:0] [, CRC-8]
// Consecutive frames are separated by P_GAP_BYTES whole bytes of zero bits.
//
// Optional feature macro: DA_FRAME_CRC_EN
//   defined   -> a CRC-8 byte (poly 0x07, init 0x00, no reflection, no final
//                XOR) over bytes 0..5 is appended, giving a 56-bit frame
//   undefined -> 48-bit frame, no CRC logic
//
// Ports
//   i_da_spi_clk  free-running DA SPI bit clock, rising-edge active
//   i_rst_n       asynchronous active-low reset
//   i_wr_vld      write request valid
//   i_wr_data     16-bit AO code
//   i_wr_ch       channel index (frame byte 1)
//   o_wr_rdy      holding buffer empty (request taken on i_wr_vld & o_wr_rdy)
//   o_da_spi_sdo  registered serial frame data
//   o_busy        frame in flight (SHIFT or GAP)
//   o_frame_done  one-cycle pulse coinciding with the first gap bit
//   o_seq         sequence number the next frame will carry
// -----------------------------------------------------------------------------
module da_frame_tx #(
  parameter int P_GAP_BYTES = 1
) (
  input  logic        i_da_spi_clk,
  input  logic        i_rst_n,
  input  logic        i_wr_vld,
  input  logic [15:0] i_wr_data,
  input  logic [7:0]  i_wr_ch,
  output logic        o_wr_rdy,
  output logic        o_da_spi_sdo,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic [7:0]  o_seq
);

`ifdef DA_FRAME_CRC_EN
  localparam int LP_LEN = 56;
`else
  localparam int LP_LEN = 48;
`endif
  localparam int LP_GAP_BITS = P_GAP_BYTES * 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [2:0]        r_bit;
  logic [1:0]        r_state;
  logic [6:0]        r_cnt;
  logic [LP_LEN-1:0] r_sr;
  logic              r_buf_vld;
  logic [7:0]        r_buf_ch;
  logic [15:0]       r_buf_data;
  logic              r_sdo;
  logic              r_done;
  logic [7:0]        r_seq;

  logic [47:0]       w_body;
  logic [LP_LEN-1:0] w_frame;
  logic              w_load;
  logic              w_gap_end;
  logic              w_start;

  assign w_body = {8'h55, r_buf_ch, r_seq, 8'h01, r_buf_data};

`ifdef DA_FRAME_CRC_EN
  // Bit-serial CRC-8 over the six frame bytes, MSB first.
  function automatic logic [7:0] crc8_48(input logic [47:0] d);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 47; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  assign w_frame = {w_body, crc8_48(w_body)};
`else
  assign w_frame = w_body;
`endif

  assign w_load    = i_wr_vld & ~r_buf_vld;
  assign w_gap_end = (r_state == ST_GAP) && (r_cnt == 7'(LP_GAP_BITS));
  // Frames only start on a byte boundary; the gap is whole bytes, so a
  // gap end is always aligned as well.
  assign w_start   = r_buf_vld && (r_bit == 3'd0) &&
                     ((r_state == ST_IDLE) || w_gap_end);

  assign o_wr_rdy     = ~r_buf_vld;
  assign o_da_spi_sdo = r_sdo;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_frame_done = r_done;
  assign o_seq        = r_seq;

  // Free-running byte phase counter.
  always_ff @(posedge i_da_spi_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit <= 3'd0;
    end else begin
      r_bit <= r_bit + 3'd1;
    end
  end

  // Holding buffer. Load and start are mutually exclusive because a load
  // needs the buffer empty and a start needs it full.
  always_ff @(posedge i_da_spi_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_buf_vld  <= 1'b0;
      r_buf_ch   <= 8'h00;
      r_buf_data <= 16'h0000;
    end else if (w_load) begin
      r_buf_vld  <= 1'b1;
      r_buf_ch   <= i_wr_ch;
      r_buf_data <= i_wr_data;
    end else if (w_start) begin
      r_buf_vld  <= 1'b0;
    end
  end

  // Frame sequencer. r_cnt counts bits already launched in SHIFT or GAP;
  // the first frame bit is launched on the start edge itself.
  always_ff @(posedge i_da_spi_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 7'd0;
      r_sr    <= '0;
      r_sdo   <= 1'b0;
      r_done  <= 1'b0;
      r_seq   <= 8'h00;
    end else begin
      r_done <= 1'b0;
      if (w_start) begin
        r_state <= ST_SHIFT;
        r_sdo   <= w_frame[LP_LEN-1];
        r_sr    <= {w_frame[LP_LEN-2:0], 1'b0};
        r_cnt   <= 7'd1;
      end else begin
        case (r_state)
          ST_SHIFT: begin
            if (r_cnt == 7'(LP_LEN)) begin
              r_state <= ST_GAP;
              r_sdo   <= 1'b0;
              r_done  <= 1'b1;
              r_seq   <= r_seq + 8'd1;
              r_cnt   <= 7'd1;
            end else begin
              r_sdo <= r_sr[LP_LEN-1];
              r_sr  <= {r_sr[LP_LEN-2:0], 1'b0};
              r_cnt <= r_cnt + 7'd1;
            end
          end
          ST_GAP: begin
            r_sdo <= 1'b0;
            if (w_gap_end) begin
              r_state <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt + 7'd1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_sdo   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_da_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_da_frame_tx
// -----------------------------------------------------------------------------
// Directed testbench for da_frame_tx. A passive monitor captures every frame
// (start edge, byte phase at start, bits) and every o_frame_done edge; the
// main initial block drives requests and compares against hand-computed
// frames, latencies and spacings.
// -----------------------------------------------------------------------------
module tb_da_frame_tx;

`ifdef DA_FRAME_CRC_EN
  localparam int LEN = 56;
`else
  localparam int LEN = 48;
`endif
  localparam int GAPB    = 1;
  localparam int SPACING = LEN + 8 * GAPB;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_vld;
  logic [15:0] wr_data;
  logic [7:0]  wr_ch;
  logic        wr_rdy;
  logic        sdo;
  logic        busy;
  logic        frame_done;
  logic [7:0]  seq;

  int checks = 0;
  int errors = 0;

  int         tb_edge = 0;
  logic [2:0] rb_model;

  logic [LEN-1:0] frames[$];
  int             start_edges[$];
  logic [2:0]     start_rbit[$];
  int             done_edges[$];
  int             idle_bad = 0;

  always #5 clk = ~clk;

  da_frame_tx #(.P_GAP_BYTES(GAPB)) dut (
    .i_da_spi_clk (clk),
    .i_rst_n      (rst_n),
    .i_wr_vld     (wr_vld),
    .i_wr_data    (wr_data),
    .i_wr_ch      (wr_ch),
    .o_wr_rdy     (wr_rdy),
    .o_da_spi_sdo (sdo),
    .o_busy       (busy),
    .o_frame_done (frame_done),
    .o_seq        (seq)
  );

  // Edge index and the byte phase the DUT should be in.
  always @(posedge clk) tb_edge <= tb_edge + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rb_model <= 3'd0;
    else        rb_model <= rb_model + 3'd1;
  end

  // Frame monitor, sampling 1 ns after each rising edge. A frame starts when
  // busy rises, or one full frame+gap after the previous start while busy
  // stays high (back-to-back).
  logic           prev_busy = 1'b0;
  int             since = 0;
  bit             capturing = 1'b0;
  int             nbits = 0;
  logic [LEN-1:0] cur;

  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      prev_busy = 1'b0;
      capturing = 1'b0;
      since     = 0;
    end else begin
      if (busy && (!prev_busy || since == SPACING)) begin
        capturing = 1'b1;
        nbits     = 0;
        since     = 0;
        start_edges.push_back(tb_edge);
        start_rbit.push_back(3'(rb_model - 3'd1));
      end
      if (capturing) begin
        cur[LEN-1-nbits] = sdo;
        nbits++;
        if (nbits == LEN) begin
          frames.push_back(cur);
          capturing = 1'b0;
        end
      end else if (sdo !== 1'b0) begin
        idle_bad++;
      end
      if (frame_done) done_edges.push_back(tb_edge);
      since++;
      prev_busy = busy;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Main-thread phase is 2 ns after a rising edge, after the monitor.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clearQueues();
    frames.delete();
    start_edges.delete();
    start_rbit.delete();
    done_edges.delete();
  endtask

  task automatic doReset();
    rst_n  = 1'b0;
    wr_vld = 1'b0;
    tick(3);
    checkOutput("rst_sdo",  64'(sdo), 64'd0);
    checkOutput("rst_rdy",  64'(wr_rdy), 64'd1);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(frame_done), 64'd0);
    checkOutput("rst_seq",  64'(seq), 64'd0);
    clearQueues();
    rst_n = 1'b1;
  endtask

  // Present one request and hold it until taken; returns the accepting edge
  // and the byte phase before that edge.
  task automatic applyStimulus(input logic [7:0] ch, input logic [15:0] data,
                               output int acc_edge, output logic [2:0] acc_rbit);
    wr_ch    = ch;
    wr_data  = data;
    wr_vld   = 1'b1;
    acc_edge = -1;
    acc_rbit = 3'd0;
    for (int t = 0; t < 400; t++) begin
      if (wr_rdy) begin
        @(posedge clk);
        #2;
        acc_edge = tb_edge;
        acc_rbit = 3'(rb_model - 3'd1);
        break;
      end
      tick(1);
    end
    wr_vld = 1'b0;
    checkOutput("accept_timeout", 64'(acc_edge >= 0), 64'd1);
  endtask

  task automatic waitFrames(input int n, input int budget);
    for (int t = 0; t < budget; t++) begin
      if (frames.size() >= n) break;
      tick(1);
    end
    checkOutput("frame_timeout", 64'(frames.size() >= n), 64'd1);
  endtask

  task automatic checkFrame(input string tag, input int idx, input logic [7:0] ch,
                            input logic [7:0] s, input logic [15:0] data);
    logic [LEN-1:0] f;
    logic [47:0]    exp48;
    f     = (idx < frames.size()) ? frames[idx] : '0;
    exp48 = {8'h55, ch, s, 8'h01, data};
    checkOutput(tag, 64'(f[LEN-1 -: 48]), 64'(exp48));
  endtask

  initial begin
    int         acc1, acc2, acc3, n0;
    logic [2:0] r1, r2, r3;

    rst_n   = 1'b0;
    wr_vld  = 1'b0;
    wr_data = 16'h0000;
    wr_ch   = 8'h00;
    #3;

    // Idle after reset.
    doReset();
    tick(64);
    checkOutput("idle_rdy",    64'(wr_rdy), 64'd1);
    checkOutput("idle_busy",   64'(busy), 64'd0);
    checkOutput("idle_seq",    64'(seq), 64'd0);
    checkOutput("idle_frames", 64'(start_edges.size()), 64'd0);
    checkOutput("idle_sdo",    64'(idle_bad), 64'd0);

    // Single frame accepted at byte phase 5 -> starts 3 edges later.
    for (int t = 0; t < 8; t++) begin
      if (rb_model == 3'd5) break;
      tick(1);
    end
    applyStimulus(8'h03, 16'hA5C3, acc1, r1);
    checkOutput("single_acc_phase", 64'(r1), 64'd5);
    waitFrames(1, 200);
    checkOutput("single_latency", 64'(start_edges[0] - acc1), 64'd3);
    checkOutput("single_start_phase", 64'(start_rbit[0]), 64'd0);
    checkFrame("single_frame", 0, 8'h03, 8'h00, 16'hA5C3);
    tick(4);
    checkOutput("single_done_cnt", 64'(done_edges.size()), 64'd1);
    checkOutput("single_done_edge", 64'(done_edges[0] - start_edges[0]), 64'(LEN));
    checkOutput("single_seq", 64'(seq), 64'd1);

    // Back-to-back: second taken right after the first start, third stalls.
    doReset();
    applyStimulus(8'h11, 16'h1234, acc1, r1);
    applyStimulus(8'h22, 16'hFFFF, acc2, r2);
    wr_ch   = 8'h33;
    wr_data = 16'h0F0F;
    wr_vld  = 1'b1;
    tick(1);
    checkOutput("third_stalled", 64'(wr_rdy), 64'd0);
    applyStimulus(8'h33, 16'h0F0F, acc3, r3);
    waitFrames(3, 400);
    checkOutput("b2b_start0", 64'(start_edges[0]), 64'(acc1 + 8 - int'(r1)));
    checkOutput("b2b_acc2", 64'(acc2 - start_edges[0]), 64'd1);
    checkOutput("b2b_space1", 64'(start_edges[1] - start_edges[0]), 64'(SPACING));
    checkOutput("b2b_acc3", 64'(acc3 - start_edges[1]), 64'd1);
    checkOutput("b2b_space2", 64'(start_edges[2] - start_edges[1]), 64'(SPACING));
    checkFrame("b2b_frame0", 0, 8'h11, 8'h00, 16'h1234);
    checkFrame("b2b_frame1", 1, 8'h22, 8'h01, 16'hFFFF);
    checkFrame("b2b_frame2", 2, 8'h33, 8'h02, 16'h0F0F);
    tick(20);
    checkOutput("b2b_done_cnt", 64'(done_edges.size()), 64'd3);
    checkOutput("b2b_done1", 64'(done_edges[1] - start_edges[1]), 64'(LEN));

    // Reset at bit 20 with an entry pending.
    n0 = start_edges.size();
    applyStimulus(8'hFF, 16'hFFFF, acc1, r1);
    for (int t = 0; t < 200; t++) begin
      if (start_edges.size() > n0) break;
      tick(1);
    end
    checkOutput("abort_started", 64'(start_edges.size() > n0), 64'd1);
    applyStimulus(8'h44, 16'h5555, acc2, r2);
    for (int t = 0; t < 100; t++) begin
      if (tb_edge >= start_edges[n0] + 20) break;
      tick(1);
    end
    checkOutput("abort_pending", 64'(wr_rdy), 64'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_sdo",  64'(sdo), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_rdy",  64'(wr_rdy), 64'd1);
    checkOutput("abort_seq",  64'(seq), 64'd0);
    tick(2);
    rst_n = 1'b1;
    n0 = start_edges.size();
    tick(120);
    checkOutput("abort_no_frame", 64'(start_edges.size() - n0), 64'd0);
    checkOutput("abort_seq_after", 64'(seq), 64'd0);

    // 257 frames: sequence wraps back to 0x00.
    doReset();
    for (int i = 0; i < 257; i++) begin
      applyStimulus(8'(i) ^ 8'hA0, 16'(i * 3), acc1, r1);
    end
    waitFrames(257, 2000);
    for (int i = 0; i < 257; i++) begin
      checkFrame("wrap_frame", i, 8'(i) ^ 8'hA0, 8'(i), 16'(i * 3));
    end
    tick(20);
    checkOutput("wrap_seq", 64'(seq), 64'd1);

`ifdef DA_FRAME_CRC_EN
    // CRC-8 of 55 00 00 01 00 00 is 0x0E.
    doReset();
    applyStimulus(8'h00, 16'h0000, acc1, r1);
    waitFrames(1, 200);
    checkFrame("crc_body", 0, 8'h00, 8'h00, 16'h0000);
    checkOutput("crc_byte", 64'(frames[0][7:0]), 64'h0E);
    tick(20);
    checkOutput("crc_len", 64'(done_edges[0] - start_edges[0]), 64'd56);
`endif

    checkOutput("gap_idle_sdo", 64'(idle_bad), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
